apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16, the number of ACCESS-phase wait cycles before forced termination (valid range 2..255).
REQ-002 The block SHALL have port pclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port preset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: per-requester transfer request.
REQ-005 The block SHALL have port req_write, input, 2 bits: per-requester direction (1 = write).
REQ-006 The block SHALL have port req_addr, input, 16 bits: requester 0 in [7:0], requester 1 in [15:8].
REQ-007 The block SHALL have port req_wdata, input, 64 bits: requester 0 in [31:0], requester 1 in [63:32].
REQ-008 The block SHALL have port req_strb, input, 8 bits: requester 0 in [3:0], requester 1 in [7:4].
REQ-009 The block SHALL have port req_ready, output, 2 bits: one-cycle accept pulse to the granted requester.
REQ-010 The block SHALL have port rsp_valid, output, 2 bits: one-cycle completion pulse to the owning requester.
REQ-011 The block SHALL have port rsp_rdata, output, 32 bits: read data, valid with rsp_valid.
REQ-012 The block SHALL have port rsp_err, output, 1 bit: error flag, valid with rsp_valid.
REQ-013 The block SHALL have APB outputs paddr (8 bits), pwdata (32), pstrb (4), psel, penable and pwrite (1 bit each).
REQ-014 The block SHALL have APB inputs prdata (32 bits), pready (1 bit) and pslverr (1 bit).

Function
REQ-015 The block SHALL use a three-state FSM: IDLE, SETUP, ACCESS; all outputs SHALL be registered.
REQ-016 In IDLE with any req_valid high, the block SHALL grant one requester, latch its addr/wdata/strb/write, pulse its req_ready and enter SETUP on the next edge.
REQ-017 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester; on a tie the preferred one wins; a lone request wins regardless of the pointer.
REQ-018 The pointer SHALL update to the non-granted requester when each transfer completes.
REQ-019 In SETUP, the block SHALL drive psel=1 and penable=0 with the latched paddr, pwrite and pwdata, and SHALL move to ACCESS after exactly one cycle.
REQ-020 In ACCESS, the block SHALL drive psel=1 and penable=1 and hold all APB outputs stable until completion.
REQ-021 When pready=1 in ACCESS, the block SHALL pulse rsp_valid for the owner, present prdata (zero for writes) and pslverr on rsp_rdata/rsp_err, drop psel/penable and return to IDLE.
REQ-022 pstrb SHALL equal the latched strobe for writes and 4'b0000 for reads.
REQ-023 Minimum transfer latency SHALL be 3 cycles from grant to rsp_valid (IDLE, SETUP, ACCESS); back-to-back transfers SHALL pass through at least one IDLE cycle.
REQ-024 req_valid changes during SETUP/ACCESS SHALL be ignored until IDLE.
REQ-025 pslverr and prdata SHALL be sampled only when psel, penable and pready are all 1.

Reset
REQ-026 On preset low, the block SHALL immediately force IDLE, pointer=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-027 Reset mid-transfer SHALL abort silently: no rsp_valid pulse SHALL follow for the aborted transfer.

Configuration
REQ-028 With APB_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL count ACCESS cycles with pready=0 and, on reaching TIMEOUT_CYC, SHALL end the transfer as in REQ-021 with rsp_err=1 and rsp_rdata=0.
REQ-029 Without APB_ARB_TIMEOUT_EN, no counter SHALL be present and ACCESS SHALL wait indefinitely for pready.

Verification
REQ-030 Requester 0 writes addr 0x10, data 0xDEADBEEF, strb 0xF, with pready tied 1 -> SETUP then ACCESS with pstrb=0xF; rsp_valid[0] 3 cycles after grant; rsp_err=0.
REQ-031 Requester 1 reads 0x24, slave returns prdata=0x12345678 after 2 wait states -> rsp_rdata=0x12345678 on rsp_valid[1]; pstrb=0 throughout.
REQ-032 Both requesters hold req_valid for 4 transfers with pointer=0 at start -> grant order 0,1,0,1.
REQ-033 Slave asserts pslverr=1 with pready on a write -> rsp_err=1 for exactly one cycle with rsp_valid.
REQ-034 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, pready held 0 -> rsp_err=1 and rsp_rdata=0 after 4 ACCESS cycles; FSM returns to IDLE.
REQ-035 preset driven low during ACCESS -> psel=0 asynchronously; no rsp_valid pulse follows; after release, a new request is granted to requester 0.

Source files
------------

// File: rtl/apb_arb_master.sv
// -----------------------------------------------------------------------------
// apb_arb_master
//
// Two-requester APB master. A round-robin arbiter picks one requester in IDLE,
// latches its command and runs a single APB transfer (SETUP then ACCESS). The
// result is returned to the owning requester as a one-cycle rsp_valid pulse.
//
// Optional feature (compile-time macro APB_ARB_TIMEOUT_EN):
//   When defined, an 8-bit counter tracks ACCESS cycles with pready low. After
//   TIMEOUT_CYC such cycles the transfer is closed with rsp_err=1, rsp_rdata=0.
//   When undefined, ACCESS waits indefinitely for pready and no counter exists.
//
// Parameters
//   TIMEOUT_CYC : ACCESS wait cycles before forced termination (2..255)
//
// Ports
//   pclk, preset          : clock, asynchronous active-low reset
//   req_valid/req_write   : per-requester request and direction (1 = write)
//   req_addr/wdata/strb   : requester 0 in the low slice, requester 1 in the high
//   req_ready             : one-cycle accept pulse to the granted requester
//   rsp_valid             : one-cycle completion pulse to the owning requester
//   rsp_rdata, rsp_err    : read data / error, valid with rsp_valid
//   paddr..pwrite         : APB master outputs (all registered)
//   prdata, pready,pslverr: APB slave response inputs
// -----------------------------------------------------------------------------
module apb_arb_master #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strb,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_cfg
    $error("apb_arb_master: TIMEOUT_CYC must be within 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ptr;      // preferred requester on a tie
  logic        r_owner;    // requester that owns the transfer in flight
  logic [1:0]  r_req_ready;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [7:0]  r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;

  logic        w_any;
  logic        w_gnt;
  logic        w_wr;
  logic [7:0]  w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_strb;
  logic        w_done;
  logic        w_tmo;

  // Arbitration: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    w_any = |req_valid;
    w_gnt = 1'b0;
    if (req_valid == 2'b11) begin
      w_gnt = r_ptr;
    end else begin
      w_gnt = req_valid[1];
    end
    w_wr    = w_gnt ? req_write[1]       : req_write[0];
    w_addr  = w_gnt ? req_addr[15:8]     : req_addr[7:0];
    w_wdata = w_gnt ? req_wdata[63:32]   : req_wdata[31:0];
    w_strb  = w_gnt ? req_strb[7:4]      : req_strb[3:0];
  end

  // Slave response is only honoured with the full psel/penable/pready handshake.
  assign w_done = (r_state == ST_ACCESS) && r_psel && r_penable && pready;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_tmo_cnt;

  // Counts stalled ACCESS cycles; cleared whenever the FSM is outside ACCESS.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_tmo_cnt <= '0;
    end else if (!pready) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  // Fires on the stalled cycle that brings the count to TIMEOUT_CYC.
  assign w_tmo = (r_state == ST_ACCESS) && !pready && (r_tmo_cnt == TMO_LAST);
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
    end else begin
      // Handshake pulses and response fields default low every cycle.
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner     <= w_gnt;
            r_req_ready <= {w_gnt, ~w_gnt};
            r_paddr     <= w_addr;
            r_pwrite    <= w_wr;
            r_pwdata    <= w_wdata;
            r_pstrb     <= w_wr ? w_strb : 4'b0000;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_done || w_tmo) begin
            r_rsp_valid <= {r_owner, ~r_owner};
            if (w_done) begin
              r_rsp_rdata <= r_pwrite ? 32'd0 : prdata;
              r_rsp_err   <= pslverr;
            end else begin
              r_rsp_rdata <= 32'd0;
              r_rsp_err   <= 1'b1;
            end
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ptr     <= ~r_owner;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;

endmodule

// File: tb/tb_apb_arb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_arb_master
//
// Directed and randomized transfers against apb_arb_master. A slave process
// answers APB accesses after a configurable number of wait states and drives
// noise on prdata/pslverr/pready whenever the handshake is incomplete. The
// expected grant winner, pointer, latency and response come from a transaction
// level model of the arbitration and completion rules.
// Build with APB_ARB_TIMEOUT_EN to also cover the timeout path (TIMEOUT_CYC=4).
// -----------------------------------------------------------------------------
module tb_apb_arb_master;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 16;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        pclk;
  logic        preset;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_arb_master #(.TIMEOUT_CYC(TMO)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave configuration for the transfer in flight.
  int          cfg_wait;
  logic [31:0] cfg_rdata;
  logic        cfg_err;
  int          s_wcnt;

  // Slave: answers after cfg_wait stalled ACCESS cycles, noise otherwise.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (s_wcnt >= cfg_wait) begin
        pready  = 1'b1;
        prdata  = cfg_rdata;
        pslverr = cfg_err;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = ($urandom_range(1) == 1);
      end
      s_wcnt++;
    end else begin
      s_wcnt  = 0;
      pready  = ($urandom_range(1) == 1);
      prdata  = $urandom;
      pslverr = ($urandom_range(1) == 1);
    end
  end

  int n_cmp;
  int n_bad;

  // Transaction-level model state.
  logic        m_ptr;
  logic [1:0]  pend;
  logic        rq_wr    [2];
  logic [7:0]  rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic [3:0]  rq_strb  [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_reqs();
    req_valid = pend;
    req_write = {rq_wr[1], rq_wr[0]};
    req_addr  = {rq_addr[1], rq_addr[0]};
    req_wdata = {rq_wdata[1], rq_wdata[0]};
    req_strb  = {rq_strb[1], rq_strb[0]};
  endtask

  task automatic rand_req(input int i);
    rq_wr[i]    = ($urandom_range(1) == 1);
    rq_addr[i]  = 8'($urandom);
    rq_wdata[i] = $urandom;
    rq_strb[i]  = 4'($urandom);
  endtask

  // One complete transfer from the IDLE grant to the response pulse.
  task automatic serve_one(input bit keep, input int wait_n, input logic [31:0] rdata,
                           input logic err, output int winner);
    int          w;
    int          lat;
    int          exp_lat;
    bit          tmo;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    w         = (pend == 2'b11) ? int'(m_ptr) : (pend[1] ? 1 : 0);
    cfg_wait  = wait_n;
    cfg_rdata = rdata;
    cfg_err   = err;
    drive_reqs();
    tick();
    exp_strb = rq_wr[w] ? rq_strb[w] : 4'h0;
    check("grant_ready", 64'(req_ready), 64'(2'b01 << w));
    check("setup_psel", 64'(psel), 64'd1);
    check("setup_penable", 64'(penable), 64'd0);
    check("setup_paddr", 64'(paddr), 64'(rq_addr[w]));
    check("setup_pwrite", 64'(pwrite), 64'(rq_wr[w]));
    check("setup_pwdata", 64'(pwdata), 64'(rq_wdata[w]));
    check("setup_pstrb", 64'(pstrb), 64'(exp_strb));
    if (!keep) pend[w] = 1'b0;
    drive_reqs();
    tick();
    check("access_psel_pen", 64'({psel, penable}), 64'd3);
    check("access_ready_low", 64'(req_ready), 64'd0);
    check("access_paddr", 64'(paddr), 64'(rq_addr[w]));
    check("access_pstrb", 64'(pstrb), 64'(exp_strb));
    tmo     = TMO_EN && (wait_n >= TMO);
    exp_lat = tmo ? TMO : wait_n + 1;
    exp_rd  = (tmo || rq_wr[w]) ? 32'd0 : rdata;
    exp_err = tmo ? 1'b1 : err;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (rsp_valid == 2'b00 && lat < 300);
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("rsp_valid", 64'(rsp_valid), 64'(2'b01 << w));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("done_psel_pen", 64'({psel, penable}), 64'd0);
    m_ptr  = (w == 0);
    winner = w;
  endtask

  initial begin
    int w;
    int wmax;
    n_cmp     = 0;
    n_bad     = 0;
    m_ptr     = 1'b0;
    pend      = 2'b00;
    cfg_wait  = 0;
    cfg_rdata = '0;
    cfg_err   = 1'b0;
    for (int i = 0; i < 2; i++) rand_req(i);
    drive_reqs();
    preset = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_psel_pen", 64'({psel, penable}), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_pstrb", 64'(pstrb), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    preset = 1'b1;
    tick();

    // Both requesters held for four transfers: alternate starting with 0.
    pend = 2'b11;
    for (int k = 0; k < 4; k++) begin
      serve_one(1'b1, 0, $urandom, 1'b0, w);
      check("rr_order", 64'(w), 64'(k % 2));
    end
    pend = 2'b00;
    drive_reqs();
    tick();
    check("idle_after_rr", 64'({psel, req_ready, rsp_valid}), 64'd0);

    // Requester 0 write, zero wait states.
    rq_wr[0] = 1'b1; rq_addr[0] = 8'h10; rq_wdata[0] = 32'hDEADBEEF; rq_strb[0] = 4'hF;
    pend = 2'b01;
    serve_one(1'b0, 0, $urandom, 1'b0, w);
    check("wr0_owner", 64'(w), 64'd0);

    // Requester 1 read with two wait states.
    rq_wr[1] = 1'b0; rq_addr[1] = 8'h24; rq_strb[1] = 4'hA;
    pend = 2'b10;
    serve_one(1'b0, 2, 32'h12345678, 1'b0, w);
    check("rd1_owner", 64'(w), 64'd1);

    // Slave error on a write: error flag lasts one cycle.
    rq_wr[0] = 1'b1; rq_addr[0] = 8'h40; rq_wdata[0] = 32'hCAFE0001; rq_strb[0] = 4'h3;
    pend = 2'b01;
    serve_one(1'b0, 1, $urandom, 1'b1, w);
    drive_reqs();
    tick();
    check("err_one_cycle", 64'({rsp_valid, rsp_err}), 64'd0);

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never answers: forced termination after TIMEOUT_CYC stalls.
    rq_wr[1] = 1'b0; rq_addr[1] = 8'h33;
    pend = 2'b10;
    serve_one(1'b0, 1000, 32'hFFFFFFFF, 1'b0, w);
    tick();
    check("tmo_back_idle", 64'({psel, penable, rsp_valid}), 64'd0);
`endif

    // Randomized rounds.
    wmax = TMO_EN ? 6 : 3;
    for (int r = 0; r < 40; r++) begin
      rand_req(0);
      rand_req(1);
      pend = 2'($urandom_range(3, 1));
      while (pend != 2'b00) begin
        serve_one(1'b0, int'($urandom_range(wmax)), $urandom,
                  ($urandom_range(3) == 0), w);
      end
      drive_reqs();
      if ($urandom_range(1) == 1) begin
        tick();
        check("rand_idle", 64'({psel, req_ready, rsp_valid}), 64'd0);
      end
    end

    // Reset during ACCESS: abort silently, pointer back to requester 0.
    rq_wr[0] = 1'b1;
    pend = 2'b01;
    serve_one(1'b0, 0, $urandom, 1'b0, w);
    rand_req(1);
    pend = 2'b10;
    cfg_wait = 1000;
    drive_reqs();
    tick();
    pend = 2'b00;
    drive_reqs();
    tick();
    check("abort_in_access", 64'({psel, penable}), 64'd3);
    #2;
    preset = 1'b0;
    #1;
    check("abort_async_psel", 64'({psel, penable}), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    m_ptr = 1'b0;
    tick();
    tick();
    preset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_rsp", 64'({rsp_valid, psel}), 64'd0);
    end
    rand_req(0);
    rand_req(1);
    pend = 2'b11;
    serve_one(1'b0, 0, $urandom, 1'b0, w);
    check("post_reset_grant", 64'(w), 64'd0);
    serve_one(1'b0, 0, $urandom, 1'b0, w);
    check("post_reset_second", 64'(w), 64'd1);
    drive_reqs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
